// File: rtl/mc_pkg.sv
// Shared definitions for the Monte Carlo pi estimator configuration path.
// Holds the frame command codes, the loader state encoding, and the mapping
// from a command to the number of payload nibbles that follow its header.
package mc_pkg;

  localparam logic [3:0] CMD_SEED  = 4'h1;
  localparam logic [3:0] CMD_LIMIT = 4'h2;
  localparam logic [3:0] CMD_BOTH  = 4'h3;
  localparam logic [3:0] CMD_CLR   = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StCheck,
    StCommit
  } cfg_state_e;

  // Payload nibble count for a header; 0 marks a header that opens no frame.
  function automatic logic [2:0] payload_len(input logic [3:0] cmd);
    logic [2:0] len;
    case (cmd)
      CMD_SEED:  len = 3'd2;
      CMD_LIMIT: len = 3'd4;
      CMD_BOTH:  len = 3'd6;
      default:   len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mc_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Usable for any slow asynchronous pin input.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset, clears all flops
//   async_in asynchronous input level
//   pulse    one-cycle pulse, high in the third cycle after async_in rises
module mc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic s1_q, s2_q, s3_q, pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= async_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pulse_q <= s2_q & ~s3_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/mc_cfg_loader.sv
// Host-to-chip configuration writer for the Monte Carlo pi estimator.
// Receives nibble frames (header, LSB-first payload, optional checksum) on a
// host strobe, validates them and commits the LFSR seed and/or sample limit.
//
// Build option: define MC_CFG_CHECKSUM_EN to require a trailing checksum
// nibble (XOR of all preceding nibbles, header included). Without it, the
// commit follows the last payload nibble directly.
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   stb    host strobe, asynchronous; rising edge marks a valid nibble
//   nib    frame nibble, stable around the strobe
//   seed   committed LFSR seed
//   limit  committed sample limit (0 = run forever)
//   load   one-cycle pulse on commit
//   busy   frame in progress
//   err    sticky error, cleared by a valid commit or a CLR command
module mc_cfg_loader
  import mc_pkg::*;
#(
  parameter logic [7:0]  SEED_DEFAULT  = 8'h48,
  parameter logic [15:0] LIMIT_DEFAULT = 16'hFFFF,
  parameter int unsigned TIMEOUT       = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic [3:0]  nib,
  output logic [7:0]  seed,
  output logic [15:0] limit,
  output logic        load,
  output logic        busy,
  output logic        err
);

  localparam logic [9:0] TO_MAX = TIMEOUT[9:0];

  logic        stb_edge;
  cfg_state_e  state_q;
  logic [3:0]  cmd_q;
  logic [2:0]  cnt_q;
  logic [2:0]  idx_q;
  logic [23:0] stage_q;
  logic [9:0]  to_q;
  logic        pend_q;
  logic [7:0]  seed_q;
  logic [15:0] limit_q;
  logic        load_q;
  logic        err_q;
`ifdef MC_CFG_CHECKSUM_EN
  logic [3:0]  csum_q;
`endif

  logic        hdr_ev;
  logic [23:0] stage_nx;
  logic [23:0] stage_fin;
  logic [7:0]  fin_seed;
  logic [15:0] fin_limit;
  logic        seed_bad;
  logic        fin_go;

  mc_sync_edge u_stb_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (stb),
    .pulse    (stb_edge)
  );

  // An edge that landed during COMMIT is replayed as a header in IDLE.
  assign hdr_ev = stb_edge | pend_q;

  always_comb begin
    stage_nx = stage_q;
    stage_nx[{idx_q, 2'b00} +: 4] = nib;
`ifdef MC_CFG_CHECKSUM_EN
    stage_fin = stage_q;
    fin_go    = stb_edge && (state_q == StCheck) && (nib == csum_q);
`else
    // Final payload nibble is committed in the same cycle it arrives.
    stage_fin = stage_nx;
    fin_go    = stb_edge && (state_q == StPayload) && (cnt_q == 3'd1);
`endif
    fin_seed  = stage_fin[7:0];
    fin_limit = (cmd_q == CMD_LIMIT) ? stage_fin[15:0] : stage_fin[23:8];
    seed_bad  = ((cmd_q == CMD_SEED) || (cmd_q == CMD_BOTH)) && (fin_seed == 8'h00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cmd_q   <= 4'h0;
      cnt_q   <= 3'd0;
      idx_q   <= 3'd0;
      stage_q <= 24'h0;
      to_q    <= 10'd0;
      pend_q  <= 1'b0;
      seed_q  <= SEED_DEFAULT;
      limit_q <= LIMIT_DEFAULT;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MC_CFG_CHECKSUM_EN
      csum_q  <= 4'h0;
`endif
    end else begin
      load_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          to_q   <= 10'd0;
          pend_q <= 1'b0;
          if (hdr_ev) begin
            if (nib == CMD_CLR) begin
              err_q <= 1'b0;
            end else if (payload_len(nib) != 3'd0) begin
              state_q <= StPayload;
              cmd_q   <= nib;
              cnt_q   <= payload_len(nib);
              idx_q   <= 3'd0;
              stage_q <= 24'h0;
`ifdef MC_CFG_CHECKSUM_EN
              csum_q  <= nib;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StPayload: begin
          if (stb_edge) begin
            stage_q <= stage_nx;
            idx_q   <= idx_q + 3'd1;
            cnt_q   <= cnt_q - 3'd1;
            to_q    <= 10'd0;
`ifdef MC_CFG_CHECKSUM_EN
            csum_q  <= csum_q ^ nib;
            if (cnt_q == 3'd1) state_q <= StCheck;
`endif
          end else if (to_q == TO_MAX) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
            to_q    <= 10'd0;
          end else begin
            to_q <= to_q + 10'd1;
          end
        end
        StCheck: begin
`ifdef MC_CFG_CHECKSUM_EN
          if (stb_edge) begin
            to_q <= 10'd0;
            if (nib != csum_q) begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end else if (to_q == TO_MAX) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
            to_q    <= 10'd0;
          end else begin
            to_q <= to_q + 10'd1;
          end
`else
          state_q <= StIdle;
`endif
        end
        StCommit: begin
          state_q <= StIdle;
          to_q    <= 10'd0;
          if (stb_edge) pend_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase

      // Frame completion overrides the per-state next state set above.
      if (fin_go) begin
        to_q <= 10'd0;
        if (seed_bad) begin
          err_q   <= 1'b1;
          state_q <= StIdle;
        end else begin
          case (cmd_q)
            CMD_SEED:  seed_q <= fin_seed;
            CMD_LIMIT: limit_q <= fin_limit;
            CMD_BOTH: begin
              seed_q  <= fin_seed;
              limit_q <= fin_limit;
            end
            default: ;
          endcase
          load_q  <= 1'b1;
          err_q   <= 1'b0;
          state_q <= StCommit;
        end
      end
    end
  end

  assign seed  = seed_q;
  assign limit = limit_q;
  assign load  = load_q;
  assign busy  = (state_q != StIdle);
  assign err   = err_q;

endmodule

// File: doc/mc_cfg_loader.md
Name: mc_cfg_loader

Overview:
- Host-to-chip configuration writer for the Monte Carlo pi estimator; the inbound counterpart to its byte-muxed result readout.
- Receives nibble frames over spare input pins with a host-driven strobe.
- Validates each frame, then commits the LFSR seed and the sample limit, so the estimator no longer runs from a fixed seed.
- Sits between the top-level pins and the estimator core. Drives seed/limit registers plus a one-cycle load pulse.

Parameters:
- SEED_DEFAULT, 8'h48, seed value after reset.
- LIMIT_DEFAULT, 16'hFFFF, sample limit after reset.
- TIMEOUT, 1023, idle clocks allowed between strobes mid-frame before the frame is aborted (10-bit counter).

Ports:
- clk  input  1  system clock (pin io_in[0]).
- rst  input  1  asynchronous, active-high reset.
- stb  input  1  host strobe; asynchronous to clk; a rising edge marks a valid nibble.
- nib  input  4  frame nibble; held stable by the host from before the stb rise until after the stb fall.
- seed  output  8  committed LFSR seed.
- limit  output  16  committed sample limit.
- load  output  1  one-cycle pulse on commit.
- busy  output  1  high while a frame is in progress (state != IDLE).
- err  output  1  sticky error flag; cleared by a valid commit or a CLR command.

Behaviour:
- Reset (async, any state):
  - seed=SEED_DEFAULT, limit=LIMIT_DEFAULT, load=0, busy=0, err=0.
  - State=IDLE; synchronizer flops and timeout counter cleared.
  - A frame in progress is discarded with no partial update.
- Strobe path:
  - stb passes through a 2-flop synchronizer, then a rising-edge detect.
  - The edge pulse arrives 3 clk after the stb rise; nib is sampled on that cycle.
  - Back-to-back edges are accepted whenever they are at least 2 clk apart after synchronization.
- Frame format: header nibble, then payload nibbles (LSB-first), then a checksum nibble (see Optional Feature).
- Commands:
  - 0x1 SEED: 2 payload nibbles.
  - 0x2 LIMIT: 4 payload nibbles.
  - 0x3 BOTH: seed 2 nibbles, then limit 4 nibbles, 6 in total.
  - 0xF CLR: no payload; clears err immediately; stays in IDLE with no load.
  - Any other header: set err, stay in IDLE.
- States:
  - IDLE: header edge -> PAYLOAD, with the payload count loaded from the command.
  - PAYLOAD: each edge shifts nib into a 24-bit staging register (nibble k into bits [4k+3:4k]). When the count reaches 0, go to CHECK if CHECKSUM_EN is defined, otherwise to COMMIT.
  - CHECK: the next edge is compared with the running XOR of header and payload. Match -> COMMIT; mismatch -> err=1, IDLE.
  - COMMIT (1 cycle): update the selected register(s), pulse load, clear err, return to IDLE.
- Commit latency: load is asserted 1 clk after the edge cycle of the final nibble.
- Seed 0x00 is illegal because it locks up the LFSR:
  - The frame is rejected: err=1, seed unchanged, no load.
  - For BOTH, limit is also left unchanged (all-or-nothing).
- Limit 0x0000 is accepted and means "run forever".
- Timeout:
  - The counter resets on every edge and runs while busy.
  - On reaching TIMEOUT: err=1, return to IDLE, staging discarded.
- load and a new header edge in the same cycle cannot occur, because COMMIT consumes no edge. An edge arriving during COMMIT is held one cycle and processed in IDLE.
- err is sticky across frames until a valid commit or CLR.

Optional Feature:
- Macro: MC_CFG_CHECKSUM_EN.
- Defined:
  - The frame ends with a checksum nibble equal to the XOR of all preceding nibbles, header included.
  - A mismatch sets err and suppresses the commit.
- Undefined:
  - There is no CHECK state; COMMIT follows the last payload nibble directly.
  - Frames are one nibble shorter.

Decomposition:
- Shared package mc_pkg holds:
  - command codes CMD_SEED=4'h1, CMD_LIMIT=4'h2, CMD_BOTH=4'h3, CMD_CLR=4'hF;
  - the state enum (IDLE, PAYLOAD, CHECK, COMMIT);
  - a payload-length function mapping command to nibble count.
- One sub-module: mc_sync_edge (2-flop synchronizer plus rising-edge pulse, async reset), reusable for other pin inputs.

Test Plan:
- After reset with no strobes: seed=8'h48, limit=16'hFFFF, load=0, busy=0, err=0.
- With MC_CFG_CHECKSUM_EN, send 1,A,5,checksum (1^A^5=E): seed=8'h5A, one load pulse 1 clk after the last edge, err=0.
- Send BOTH 3,4,3,0,1,0,0 with checksum 5: seed=8'h34, limit=16'h0010, single load.
- Send SEED with payload 0,0 (checksum 1) -> err=1, seed stays 8'h48. Wrong checksum on a LIMIT frame -> err=1, limit unchanged. Then send CLR F -> err=0, no load.
- Send header 2 plus one payload nibble, then no strobes for 1024 clk -> err=1, busy=0, limit unchanged. A following valid frame commits normally.
- Assert rst for 1 clk mid-PAYLOAD of a BOTH frame: outputs immediately return to their defaults. The resumed nibbles are parsed as a new header, and an invalid header sets err.
